// File: rtl/arch_map_release_pkg.sv
// arch_map_release_pkg
//   Shared sizing, types and restore-FSM encoding for the architectural map
//   table release block (arch_map_release and its amt_regfile).
//   No ports; imported by every file of the block.
package arch_map_release_pkg;

    localparam int NUM_LOGICAL  = 32;
    localparam int LOG_LOGICAL  = 5;
    localparam int PHYS_LOG     = 7;
    localparam int COMMIT_WIDTH = 4;
    localparam int CNT_W        = LOG_LOGICAL - 2;
    localparam int NUM_BEATS    = NUM_LOGICAL / COMMIT_WIDTH;

    typedef logic [LOG_LOGICAL-1:0] log_idx_t;
    typedef logic [PHYS_LOG-1:0]    phys_idx_t;
    typedef logic [CNT_W-1:0]       beat_cnt_t;

    typedef struct packed {
        logic      valid;
        log_idx_t  log_dest;
        phys_idx_t phy_dest;
    } retire_slot_t;

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_BEATS - 1);

    // Restore FSM encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RESTORE = 1'b1;

endpackage

// File: rtl/arch_map_release_amt.sv
// amt_regfile
//   Architectural map table storage: NUM_LOGICAL entries of PHYS_LOG bits.
//   Ports:
//     clk, reset          clock, async active-high reset (entries -> identity)
//     wr_en_i/idx/data    COMMIT_WIDTH write ports; higher port wins on a clash
//     rd_idx_i/rd_data_o  2*COMMIT_WIDTH combinational read ports
import arch_map_release_pkg::*;

module amt_regfile (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] wr_en_i,
    input  log_idx_t                wr_idx_i  [COMMIT_WIDTH],
    input  phys_idx_t               wr_data_i [COMMIT_WIDTH],
    input  log_idx_t                rd_idx_i  [2*COMMIT_WIDTH],
    output phys_idx_t               rd_data_o [2*COMMIT_WIDTH]
);

    phys_idx_t amt_q [NUM_LOGICAL];
    phys_idx_t amt_d [NUM_LOGICAL];

    // Later ports overwrite earlier ones: youngest retiring slot owns the entry.
    always_comb begin
        for (int i = 0; i < NUM_LOGICAL; i++) begin
            amt_d[i] = amt_q[i];
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (wr_en_i[k]) begin
                amt_d[wr_idx_i[k]] = wr_data_i[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOGICAL; i++) begin
                amt_q[i] <= phys_idx_t'(i);
            end
        end else begin
            for (int i = 0; i < NUM_LOGICAL; i++) begin
                amt_q[i] <= amt_d[i];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 2*COMMIT_WIDTH; r++) begin
            rd_data_o[r] = amt_q[rd_idx_i[r]];
        end
    end

endmodule

// File: rtl/arch_map_release.sv
// arch_map_release
//   Retire-side producer for the free list. Holds the committed logical->physical
//   map, releases the superseded mapping of each retiring dest (registered,
//   slot-aligned), and on recovery streams the map out four entries per beat.
//   Ports:
//     clk, reset                      clock, async active-high reset
//     retireValid/LogDest/PhyDest k   retire bundle, slot 0 oldest
//     recoverFlag_i                   start (or restart) the restore stream
//     commitValid/commitReg k         free-list pushes, one cycle after retire
//     restoreBusy_o/restoreValid_o    restore stream in progress / beat valid
//     restoreIdx_o, restoreMap k      beat base index and map entries
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | retire accepted, no stream
//   ST_RESTORE | streaming beat cnt_q; retire dropped
import arch_map_release_pkg::*;

module arch_map_release (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   retireValid0_i,
    input  logic                   retireValid1_i,
    input  logic                   retireValid2_i,
    input  logic                   retireValid3_i,
    input  logic [LOG_LOGICAL-1:0] retireLogDest0_i,
    input  logic [LOG_LOGICAL-1:0] retireLogDest1_i,
    input  logic [LOG_LOGICAL-1:0] retireLogDest2_i,
    input  logic [LOG_LOGICAL-1:0] retireLogDest3_i,
    input  logic [PHYS_LOG-1:0]    retirePhyDest0_i,
    input  logic [PHYS_LOG-1:0]    retirePhyDest1_i,
    input  logic [PHYS_LOG-1:0]    retirePhyDest2_i,
    input  logic [PHYS_LOG-1:0]    retirePhyDest3_i,
    input  logic                   recoverFlag_i,
    output logic                   commitValid0_o,
    output logic                   commitValid1_o,
    output logic                   commitValid2_o,
    output logic                   commitValid3_o,
    output logic [PHYS_LOG-1:0]    commitReg0_o,
    output logic [PHYS_LOG-1:0]    commitReg1_o,
    output logic [PHYS_LOG-1:0]    commitReg2_o,
    output logic [PHYS_LOG-1:0]    commitReg3_o,
    output logic                   restoreBusy_o,
    output logic                   restoreValid_o,
    output logic [LOG_LOGICAL-1:0] restoreIdx_o,
    output logic [PHYS_LOG-1:0]    restoreMap0_o,
    output logic [PHYS_LOG-1:0]    restoreMap1_o,
    output logic [PHYS_LOG-1:0]    restoreMap2_o,
    output logic [PHYS_LOG-1:0]    restoreMap3_o
);

    retire_slot_t            slot [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] wr_en;
    log_idx_t                wr_idx   [COMMIT_WIDTH];
    phys_idx_t               wr_data  [COMMIT_WIDTH];
    log_idx_t                rd_idx   [2*COMMIT_WIDTH];
    phys_idx_t               rd_data  [2*COMMIT_WIDTH];
    phys_idx_t               old_reg  [COMMIT_WIDTH];

    logic [0:0]              state_q, state_d;
    beat_cnt_t               cnt_q, cnt_d;
    logic [COMMIT_WIDTH-1:0] commit_valid_q, commit_valid_d;
    phys_idx_t               commit_reg_q [COMMIT_WIDTH];
    phys_idx_t               commit_reg_d [COMMIT_WIDTH];
    logic                    restoring;

    assign slot[0] = '{retireValid0_i, retireLogDest0_i, retirePhyDest0_i};
    assign slot[1] = '{retireValid1_i, retireLogDest1_i, retirePhyDest1_i};
    assign slot[2] = '{retireValid2_i, retireLogDest2_i, retirePhyDest2_i};
    assign slot[3] = '{retireValid3_i, retireLogDest3_i, retirePhyDest3_i};

    assign restoring = (state_q == ST_RESTORE);

    // Ports 0..3 look up retiring dests, ports 4..7 read the current beat.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            wr_en[k]                 = slot[k].valid & ~restoring;
            wr_idx[k]                = slot[k].log_dest;
            wr_data[k]               = slot[k].phy_dest;
            rd_idx[k]                = slot[k].log_dest;
            rd_idx[COMMIT_WIDTH + k] = {cnt_q, 2'(k)};
        end
    end

    amt_regfile u_amt (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    // An older slot of the same bundle writing the same dest supersedes the
    // table value; scanning oldest to youngest leaves the nearest older writer.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            old_reg[k] = rd_data[k];
            for (int j = 0; j < k; j++) begin
                if (wr_en[j] && (slot[j].log_dest == slot[k].log_dest)) begin
                    old_reg[k] = slot[j].phy_dest;
                end
            end
        end
    end

    always_comb begin
        commit_valid_d = wr_en;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            commit_reg_d[k] = wr_en[k] ? old_reg[k] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (recoverFlag_i) begin
                state_d = ST_RESTORE;
                cnt_d   = '0;
            end
        end else begin
            if (recoverFlag_i) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_BEAT) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            commit_valid_q <= '0;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                commit_reg_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            commit_valid_q <= commit_valid_d;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                commit_reg_q[k] <= commit_reg_d[k];
            end
        end
    end

    assign commitValid0_o = commit_valid_q[0];
    assign commitValid1_o = commit_valid_q[1];
    assign commitValid2_o = commit_valid_q[2];
    assign commitValid3_o = commit_valid_q[3];
    assign commitReg0_o   = commit_reg_q[0];
    assign commitReg1_o   = commit_reg_q[1];
    assign commitReg2_o   = commit_reg_q[2];
    assign commitReg3_o   = commit_reg_q[3];

    assign restoreBusy_o  = restoring;
    assign restoreValid_o = restoring;
    assign restoreIdx_o   = restoring ? {cnt_q, 2'b00} : '0;
    assign restoreMap0_o  = restoring ? rd_data[COMMIT_WIDTH + 0] : '0;
    assign restoreMap1_o  = restoring ? rd_data[COMMIT_WIDTH + 1] : '0;
    assign restoreMap2_o  = restoring ? rd_data[COMMIT_WIDTH + 2] : '0;
    assign restoreMap3_o  = restoring ? rd_data[COMMIT_WIDTH + 3] : '0;

endmodule

// File: tb/tb_arch_map_release.sv
module tb_arch_map_release;

    localparam int NL = 32;
    localparam int NUM_PHYSICAL = 128;

    logic       clk;
    logic       reset;
    logic       rv [4];
    logic [4:0] rl [4];
    logic [6:0] rp [4];
    logic       recover;

    logic       cv [4];
    logic [6:0] cr [4];
    logic       busy, rvalid;
    logic [4:0] ridx;
    logic [6:0] rmap [4];

    arch_map_release dut (
        .clk              (clk),
        .reset            (reset),
        .retireValid0_i   (rv[0]),
        .retireValid1_i   (rv[1]),
        .retireValid2_i   (rv[2]),
        .retireValid3_i   (rv[3]),
        .retireLogDest0_i (rl[0]),
        .retireLogDest1_i (rl[1]),
        .retireLogDest2_i (rl[2]),
        .retireLogDest3_i (rl[3]),
        .retirePhyDest0_i (rp[0]),
        .retirePhyDest1_i (rp[1]),
        .retirePhyDest2_i (rp[2]),
        .retirePhyDest3_i (rp[3]),
        .recoverFlag_i    (recover),
        .commitValid0_o   (cv[0]),
        .commitValid1_o   (cv[1]),
        .commitValid2_o   (cv[2]),
        .commitValid3_o   (cv[3]),
        .commitReg0_o     (cr[0]),
        .commitReg1_o     (cr[1]),
        .commitReg2_o     (cr[2]),
        .commitReg3_o     (cr[3]),
        .restoreBusy_o    (busy),
        .restoreValid_o   (rvalid),
        .restoreIdx_o     (ridx),
        .restoreMap0_o    (rmap[0]),
        .restoreMap1_o    (rmap[1]),
        .restoreMap2_o    (rmap[2]),
        .restoreMap3_o    (rmap[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: committed map as a plain array, restore progress as a
    // beat number (-1 = not restoring), free pool as a queue.
    int amt [NL];
    int rest_beat;
    int exp_cv [4];
    int exp_cr [4];
    int pool [$];
    bit use_pool;
    bit run_cmp;
    int tests;
    int fails;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) amt[i] = i;
        rest_beat = -1;
        for (int k = 0; k < 4; k++) begin
            exp_cv[k] = 0;
            exp_cr[k] = 0;
        end
        pool.delete();
        for (int p = NL; p < NUM_PHYSICAL; p++) pool.push_back(p);
    endtask

    // Applies the inputs present at the edge just taken.
    task automatic model_step();
        int any_ret;
        int freed [$];
        any_ret = 0;
        for (int k = 0; k < 4; k++) any_ret += int'(rv[k]);
        if (rest_beat >= 0) begin
            check("no_retire_in_restore", any_ret, 0);
            for (int k = 0; k < 4; k++) begin
                exp_cv[k] = 0;
                exp_cr[k] = 0;
            end
            if (recover) rest_beat = 0;
            else begin
                rest_beat++;
                if (rest_beat == NL/4) rest_beat = -1;
            end
        end else begin
            // Program-order semantics: each slot sees all older slots' writes.
            for (int k = 0; k < 4; k++) begin
                exp_cv[k] = int'(rv[k]);
                exp_cr[k] = 0;
                if (rv[k]) begin
                    exp_cr[k] = amt[rl[k]];
                    amt[rl[k]] = int'(rp[k]);
                    freed.push_back(exp_cr[k]);
                end
            end
            if (use_pool) begin
                foreach (freed[f]) begin
                    int live_hits, pool_hits;
                    live_hits = 0;
                    pool_hits = 0;
                    for (int i = 0; i < NL; i++) if (amt[i] == freed[f]) live_hits++;
                    foreach (pool[q]) if (pool[q] == freed[f]) pool_hits++;
                    check("freed_not_live", live_hits, 0);
                    check("freed_unique", pool_hits, 0);
                    pool.push_back(freed[f]);
                end
                check("pool_plus_live", pool.size() + NL, NUM_PHYSICAL);
            end
            if (recover) rest_beat = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && run_cmp) begin
            int b;
            b = (rest_beat >= 0) ? 1 : 0;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("commitValid%0d", k), int'(cv[k]), exp_cv[k]);
                check($sformatf("commitReg%0d", k), int'(cr[k]), exp_cr[k]);
                check($sformatf("restoreMap%0d", k), int'(rmap[k]),
                      b ? amt[4*rest_beat + k] : 0);
            end
            check("restoreBusy", int'(busy), b);
            check("restoreValid", int'(rvalid), b);
            check("restoreIdx", int'(ridx), b ? 4*rest_beat : 0);
        end
    end

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            rv[k] = 1'b0;
            rl[k] = '0;
            rp[k] = '0;
        end
        recover = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (!reset) model_step();
        clear_inputs();
    endtask

    initial begin
        int nb;
        tests = 0;
        fails = 0;
        use_pool = 1'b0;
        run_cmp = 1'b0;
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #3;
        check("reset_commitValid0", int'(cv[0]), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_restoreIdx", int'(ridx), 0);
        cycle();
        cycle();
        reset = 1'b0;
        run_cmp = 1'b1;

        // Single retire
        rv[0] = 1'b1; rl[0] = 5'd3; rp[0] = 7'd40;
        cycle();
        check("t1_cv0", int'(cv[0]), 1);
        check("t1_cr0", int'(cr[0]), 3);

        // Same dest in slots 0..2
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b1; rl[k] = 5'd5; rp[k] = 7'(41 + k);
        end
        cycle();
        check("t2_cr0", int'(cr[0]), 5);
        check("t2_cr1", int'(cr[1]), 41);
        check("t2_cr2", int'(cr[2]), 42);
        check("t2_cv2", int'(cv[2]), 1);

        // Sparse valids keep slot alignment; invalid slots carry junk
        rv[1] = 1'b1; rl[1] = 5'd7; rp[1] = 7'd44;
        rv[3] = 1'b1; rl[3] = 5'd9; rp[3] = 7'd45;
        rl[0] = 5'd3; rp[0] = 7'd99;
        rl[2] = 5'd5; rp[2] = 7'd98;
        cycle();
        check("t3_cv_vec", int'({cv[3], cv[2], cv[1], cv[0]}), 4'b1010);
        check("t3_cr0", int'(cr[0]), 0);
        check("t3_cr2", int'(cr[2]), 0);
        check("t3_cr1", int'(cr[1]), 7);
        check("t3_cr3", int'(cr[3]), 9);

        // Full restore stream
        recover = 1'b1;
        cycle();
        check("t4_busy", int'(busy), 1);
        check("t4_idx0", int'(ridx), 0);
        check("t4_map0", int'(rmap[0]), 0);
        check("t4_map1", int'(rmap[1]), 1);
        check("t4_map2", int'(rmap[2]), 2);
        check("t4_map3", int'(rmap[3]), 40);
        nb = 1;
        for (int c = 1; c < 11; c++) begin
            cycle();
            if (c == 1) begin
                check("t4_b1_map1", int'(rmap[1]), 43);
                check("t4_b1_map3", int'(rmap[3]), 44);
            end
            if (c == 2) check("t4_b2_map1", int'(rmap[1]), 45);
            if (busy) begin
                check("t4_idx_seq", int'(ridx), 4*nb);
                nb++;
            end
        end
        check("t4_busy_cycles", nb, 8);

        // Restart at beat 5, then reset at beat 3
        recover = 1'b1;
        cycle();
        for (int c = 0; c < 5; c++) cycle();
        check("t5_beat5_idx", int'(ridx), 20);
        recover = 1'b1;
        cycle();
        check("t5_restart_idx", int'(ridx), 0);
        check("t5_restart_busy", int'(busy), 1);
        for (int c = 0; c < 3; c++) cycle();
        check("t5_beat3_idx", int'(ridx), 12);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_valid", int'(rvalid), 0);
        check("t5_rst_idx", int'(ridx), 0);
        check("t5_rst_map0", int'(rmap[0]), 0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        recover = 1'b1;
        cycle();
        check("t5_ident_map3", int'(rmap[3]), 3);
        check("t5_ident_map2", int'(rmap[2]), 2);
        for (int c = 0; c < 9; c++) cycle();

        // Randomized retire / recover traffic against the model
        use_pool = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (rest_beat < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1 && pool.size() > 0) begin
                        rv[k] = 1'b1;
                        rl[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                            : 5'($urandom_range(0, 31));
                        rp[k] = 7'(pool.pop_front());
                    end
                end
                recover = ($urandom_range(0, 39) == 0);
            end else begin
                recover = ($urandom_range(0, 11) == 0);
            end
            cycle();
        end
        for (int c = 0; c < 12; c++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
